ram_port_arbiter: RTL and testbench

Shares the single-port program RAM between the CPU data port and a host readout port.
The CPU gets single-word read/write accesses. The host gets word reads, which the block then streams out LSB-byte-first, one byte per cycle, on the 8-bit output pins.
Round-robin arbitration with registered RAM controls; it replaces ad-hoc free-running serialization of RAM contents.

---
 rtl/ram_port_arbiter.sv | 132 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM between a CPU data
// port (single-word reads/writes) and a host readout port (word reads that are
// streamed out LSB byte first, one byte per cycle). Round-robin arbitration,
// all RAM controls registered.
//
// Handshake: a requester raises *_req with its address (and CPU write data and
// cpu_we) and holds everything stable until it sees its one-cycle *_gnt pulse.
// *_gnt marks the cycle the access is on the RAM pins. A requester is never
// eligible in its own gnt cycle, so a request held through gnt is not granted
// twice. The host is also ignored while host_busy is high.
module ram_port_arbiter #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          host_req,
   input  logic [AW-1:0] host_addr,
   output logic          host_gnt,
   output logic          host_busy,
   output logic [7:0]    host_byte,
   output logic          host_byte_valid,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam int NB = DW / 8;
   localparam int CW = $clog2(NB + 1);

   // Arbitration / RAM control state
   logic          r_cpu_gnt;
   logic          r_host_gnt;
   logic          r_last_host;   // 1: last grant went to the host
   logic          r_ram_we;
   logic [AW-1:0] r_ram_addr;
   logic [DW-1:0] r_ram_wdata;

   // Read return / serializer state
   logic          r_cpu_rvalid;
   logic          r_host_cap;    // host read data is on ram_rdata this cycle
   logic [DW-1:0] r_word;        // host word, shifted right one byte per cycle
   logic [CW-1:0] r_cnt;         // bytes still to emit

   logic w_host_busy;
   logic w_cpu_elig;
   logic w_host_elig;
   logic w_grant_cpu;
   logic w_grant_host;

   // Host is busy from its gnt cycle until the cycle after its last byte.
   assign w_host_busy = r_host_gnt | r_host_cap | (r_cnt != '0);

   // Eligibility and round-robin choice for the edge ending this cycle.
   always_comb begin
      w_cpu_elig   = cpu_req & ~r_cpu_gnt;
      w_host_elig  = host_req & ~w_host_busy & ~r_host_gnt;
      w_grant_cpu  = w_cpu_elig & (~w_host_elig | r_last_host);
      w_grant_host = w_host_elig & ~w_grant_cpu;
   end

   // Register the grant and drive the RAM pins in the following (issue) cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpu_gnt   <= 1'b0;
         r_host_gnt  <= 1'b0;
         r_last_host <= 1'b1;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
      end else begin
         r_cpu_gnt  <= w_grant_cpu;
         r_host_gnt <= w_grant_host;
         r_ram_we   <= w_grant_cpu & cpu_we;
         if (w_grant_cpu) begin
            r_ram_addr  <= cpu_addr;
            r_ram_wdata <= cpu_wdata;
            r_last_host <= 1'b0;
         end else if (w_grant_host) begin
            r_ram_addr  <= host_addr;
            r_last_host <= 1'b1;
         end
      end
   end

   // CPU read data arrives the cycle after the issue cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpu_rvalid <= 1'b0;
      end else begin
         r_cpu_rvalid <= r_cpu_gnt & ~r_ram_we;
      end
   end

   // Host serializer: capture the word one cycle after issue, then shift bytes out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_host_cap <= 1'b0;
         r_word     <= '0;
         r_cnt      <= '0;
      end else begin
         r_host_cap <= r_host_gnt;
         if (r_host_cap) begin
            r_word <= ram_rdata;
            r_cnt  <= CW'(NB);
         end else if (r_cnt != '0) begin
            r_word <= {8'h00, r_word[DW-1:8]};
            r_cnt  <= r_cnt - CW'(1);
         end
      end
   end

   assign cpu_gnt         = r_cpu_gnt;
   assign host_gnt        = r_host_gnt;
   assign host_busy       = w_host_busy;
   assign cpu_rvalid      = r_cpu_rvalid;
   assign cpu_rdata       = r_cpu_rvalid ? ram_rdata : '0;
   assign host_byte_valid = (r_cnt != '0);
   assign host_byte       = (r_cnt != '0) ? r_word[7:0] : 8'h00;
   assign ram_we          = r_ram_we;
   assign ram_addr        = r_ram_addr;
   assign ram_wdata       = r_ram_wdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 1-cycle-latency RAM,
// expected-read queues and a negedge monitor that consumes them.
module tb_ram_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          host_req = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic          host_gnt;
  logic          host_busy;
  logic [7:0]    host_byte;
  logic          host_byte_valid;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic [DW-1:0] exp_q[$];
  logic [7:0]    host_q[$];

  int n_pass = 0;
  int n_chk  = 0;

  bit tie_cpu  [1:10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  bit tie_host [1:10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  bit tie_busy [1:10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  // clock / reset
  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
    .host_busy(host_busy), .host_byte(host_byte), .host_byte_valid(host_byte_valid),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // synchronous RAM, one cycle read latency
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_host_word(input logic [DW-1:0] w);
    for (int k = 0; k < NB; k++) host_q.push_back(w[8*k +: 8]);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
    chk("wr_cpu_gnt", 32'(cpu_gnt), 1);
    chk("wr_ram_we", 32'(ram_we), 1);
    chk("wr_ram_addr", 32'(ram_addr), 32'(a));
    chk("wr_ram_wdata", ram_wdata, d);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    chk("wr_ram_we_one_cycle", 32'(ram_we), 0);
    chk("wr_ram_addr_hold", 32'(ram_addr), 32'(a));
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    tick();
    chk("rd_cpu_gnt", 32'(cpu_gnt), 1);
    chk("rd_ram_we", 32'(ram_we), 0);
    chk("rd_ram_addr", 32'(ram_addr), 32'(a));
    exp_q.push_back(d);
    cpu_req = 1'b0;
    tick();
    chk("rd_rvalid_t2", 32'(cpu_rvalid), 1);
    tick();
    chk("rd_rvalid_one_cycle", 32'(cpu_rvalid), 0);
  endtask

  // scoreboard monitor: consumes expected queues when the DUT produces data
  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (exp_q.size() == 0) chk("cpu_rvalid_unexpected", 32'(cpu_rvalid), 0);
      else chk("cpu_rdata", cpu_rdata, exp_q.pop_front());
    end
    if (host_byte_valid) begin
      if (host_q.size() == 0) chk("host_byte_unexpected", 32'(host_byte_valid), 0);
      else chk("host_byte", 32'(host_byte), 32'(host_q.pop_front()));
    end else begin
      chk("host_byte_idle_zero", 32'(host_byte), 0);
    end
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
    chk("rst_host_gnt", 32'(host_gnt), 0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_host_busy", 32'(host_busy), 0);
    chk("rst_host_byte_valid", 32'(host_byte_valid), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_cpu_gnt", 32'(cpu_gnt), 0);

    // CPU write then read, plus preload for host tests
    cpu_write(5'd3, 32'hDEADBEEF);
    cpu_read(5'd3, 32'hDEADBEEF);
    cpu_write(5'd5, 32'h11223344);
    cpu_write(5'd7, 32'hCAFEF00D);

    // host stream of addr 5
    host_req = 1'b1; host_addr = 5'd5;
    tick();
    chk("hs_host_gnt", 32'(host_gnt), 1);
    chk("hs_busy_t1", 32'(host_busy), 1);
    chk("hs_ram_addr", 32'(ram_addr), 5);
    chk("hs_ram_we", 32'(ram_we), 0);
    host_req = 1'b0;
    push_host_word(32'h11223344);
    tick();
    chk("hs_busy_t2", 32'(host_busy), 1);
    chk("hs_valid_t2", 32'(host_byte_valid), 0);
    chk("hs_gnt_once", 32'(host_gnt), 0);
    for (int k = 0; k < NB; k++) begin
      tick();
      chk("hs_valid_stream", 32'(host_byte_valid), 1);
      chk("hs_busy_stream", 32'(host_busy), 1);
    end
    tick();
    chk("hs_busy_end", 32'(host_busy), 0);
    chk("hs_valid_end", 32'(host_byte_valid), 0);

    // CPU read of addr 7 during host serialization of addr 5
    host_req = 1'b1; host_addr = 5'd5;
    tick();
    chk("cc_host_gnt", 32'(host_gnt), 1);
    host_req = 1'b0;
    push_host_word(32'h11223344);
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd7;
    tick();
    chk("cc_cpu_gnt", 32'(cpu_gnt), 1);
    chk("cc_ram_addr", 32'(ram_addr), 7);
    chk("cc_valid_b0", 32'(host_byte_valid), 1);
    exp_q.push_back(32'hCAFEF00D);
    cpu_req = 1'b0;
    tick();
    chk("cc_cpu_rvalid", 32'(cpu_rvalid), 1);
    chk("cc_valid_b1", 32'(host_byte_valid), 1);
    tick();
    chk("cc_valid_b2", 32'(host_byte_valid), 1);
    tick();
    chk("cc_valid_b3", 32'(host_byte_valid), 1);
    tick();
    chk("cc_busy_end", 32'(host_busy), 0);

    // CPU request held for 6 cycles, host idle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd3;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("held_cpu_gnt", 32'(cpu_gnt), 32'(k % 2));
      if (k % 2 == 1) exp_q.push_back(32'hDEADBEEF);
    end
    cpu_req = 1'b0;
    tick();
    chk("held_cpu_gnt_after", 32'(cpu_gnt), 0);
    tick();

    // tie and fairness: both requests held from reset release
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd7;
    host_req = 1'b1; host_addr = 5'd5;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("tie_cpu_gnt", 32'(cpu_gnt), 32'(tie_cpu[k]));
      chk("tie_host_gnt", 32'(host_gnt), 32'(tie_host[k]));
      chk("tie_host_busy", 32'(host_busy), 32'(tie_busy[k]));
      if (tie_cpu[k]) exp_q.push_back(32'hCAFEF00D);
      if (tie_host[k]) push_host_word(32'h11223344);
    end
    cpu_req = 1'b0; host_req = 1'b0;
    repeat (8) tick();
    chk("tie_host_busy_end", 32'(host_busy), 0);

    // async reset at byte 2 of a stream, with a CPU write on the RAM pins
    host_req = 1'b1; host_addr = 5'd5;
    tick();
    chk("ar_host_gnt", 32'(host_gnt), 1);
    host_req = 1'b0;
    push_host_word(32'h11223344);
    tick();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd9; cpu_wdata = 32'h55AA55AA;
    tick();
    chk("ar_valid_before", 32'(host_byte_valid), 1);
    chk("ar_ram_we_before", 32'(ram_we), 1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_now", 32'(host_byte_valid), 0);
    chk("ar_busy_now", 32'(host_busy), 0);
    chk("ar_ram_we_now", 32'(ram_we), 0);
    chk("ar_host_byte_now", 32'(host_byte), 0);
    host_q.delete();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("ar_no_bytes", 32'(host_byte_valid), 0);
      chk("ar_no_busy", 32'(host_busy), 0);
      chk("ar_no_gnt", 32'(host_gnt), 0);
    end

    // every expected read must have been consumed
    chk("cpu_q_drained", 32'(exp_q.size()), 0);
    chk("host_q_drained", 32'(host_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
